// File: rtl/my_out_capture_if.sv
// Capture/drain bus for my_out_capture.
// The producer drives cap_*, the consumer drives rd_ready, and the FIFO drives rd_*.
// The slave modport is the FIFO side.
// The master modport is the producer/consumer (bench) side.
interface my_out_capture_if #(
    parameter int W_SMALL = 2,
    parameter int W_QUAD  = 40,
    parameter int W_WIDE  = 70
);
    logic               cap_valid;
    logic [W_SMALL-1:0] cap_small;
    logic [W_QUAD-1:0]  cap_quad;
    logic [W_WIDE-1:0]  cap_wide;
    logic               rd_valid;
    logic               rd_ready;
    logic [W_SMALL-1:0] rd_small;
    logic [W_QUAD-1:0]  rd_quad;
    logic [W_WIDE-1:0]  rd_wide;

    modport slave (
        input  cap_valid, cap_small, cap_quad, cap_wide, rd_ready,
        output rd_valid, rd_small, rd_quad, rd_wide
    );

    modport master (
        output cap_valid, cap_small, cap_quad, cap_wide, rd_ready,
        input  rd_valid, rd_small, rd_quad, rd_wide
    );
endinterface

// File: rtl/my_out_capture.sv
// Output capture FIFO for the incrementer datapath.
// The producer cannot stall, so the FIFO never back-pressures it.
// Instead, captures that arrive while the FIFO is full are dropped and counted.
// Reads are show-ahead: the head entry is presented combinationally on rd_*.
// Optional macro MY_OUT_CAPTURE_CHKSUM_EN builds an XOR checksum over all pushed entries.
// When the macro is not defined, chk is tied to 0.
module my_out_capture #(
    parameter int DEPTH   = 4,
    parameter int W_SMALL = 2,
    parameter int W_QUAD  = 40,
    parameter int W_WIDE  = 70
) (
    input  logic                     clk,
    input  logic                     reset_l,
    my_out_capture_if.slave          bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     ovf,
    output logic [15:0]              ovf_cnt,
    output logic [W_WIDE-1:0]        chk
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int W  = W_SMALL + W_QUAD + W_WIDE;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          ovf_q;
    logic [15:0]   ovf_cnt_q;
    logic [W-1:0]  head;
    logic          push;
    logic          pop;
    logic          drop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign ovf     = ovf_q;
    assign ovf_cnt = ovf_cnt_q;

    // A pop in the same cycle frees a slot, so a capture into a full FIFO is still accepted.
    assign pop  = !empty && bus.rd_ready;
    assign push = bus.cap_valid && (!full || pop);
    assign drop = bus.cap_valid && full && !pop;

    // Show-ahead head entry, forced to zero while there is nothing to read.
    assign head         = empty ? '0 : mem[rd_ptr];
    assign bus.rd_valid = !empty;
    assign bus.rd_small = head[W-1 -: W_SMALL];
    assign bus.rd_quad  = head[W_WIDE +: W_QUAD];
    assign bus.rd_wide  = head[W_WIDE-1:0];

    // Storage write; memory is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.cap_small, bus.cap_quad, bus.cap_wide};
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            ovf_q     <= 1'b0;
            ovf_cnt_q <= '0;
        end else if (drop) begin
            ovf_q <= 1'b1;
            if (ovf_cnt_q != 16'hFFFF) ovf_cnt_q <= ovf_cnt_q + 16'd1;
        end
    end

`ifdef MY_OUT_CAPTURE_CHKSUM_EN
    logic [W_WIDE-1:0] chk_q;

    // XOR checksum over accepted captures only; it is updated on the same edge as the write.
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            chk_q <= '0;
        end else if (push) begin
            chk_q <= chk_q ^ bus.cap_wide ^ W_WIDE'(bus.cap_quad) ^ W_WIDE'(bus.cap_small);
        end
    end

    assign chk = chk_q;
`else
    assign chk = '0;
`endif

endmodule

// File: tb/tb_my_out_capture.sv
// Directed testbench for my_out_capture.
// Inputs are driven and outputs sampled on the falling edge.
module tb_my_out_capture;
    logic clk = 1'b0;
    logic reset_l;
    logic [2:0]  count;
    logic        full;
    logic        empty;
    logic        ovf;
    logic [15:0] ovf_cnt;
    logic [69:0] chk;

    int compared   = 0;
    int mismatched = 0;

    localparam logic [69:0] ONES70 = 70'h3F_FFFF_FFFF_FFFF_FFFF;

    always #5 clk = ~clk;

    my_out_capture_if #(.W_SMALL(2), .W_QUAD(40), .W_WIDE(70)) bus ();

    my_out_capture #(.DEPTH(4), .W_SMALL(2), .W_QUAD(40), .W_WIDE(70)) dut (
        .clk     (clk),
        .reset_l (reset_l),
        .bus     (bus),
        .count   (count),
        .full    (full),
        .empty   (empty),
        .ovf     (ovf),
        .ovf_cnt (ovf_cnt),
        .chk     (chk)
    );

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_one(input logic [1:0] s, input logic [39:0] q, input logic [69:0] w);
        bus.cap_valid = 1'b1;
        bus.cap_small = s;
        bus.cap_quad  = q;
        bus.cap_wide  = w;
        step();
        bus.cap_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [1:0] s, input logic [39:0] q,
                             input logic [69:0] w);
        check_val({tag, "_valid"}, bus.rd_valid, 1'b1);
        check_val({tag, "_small"}, bus.rd_small, s);
        check_val({tag, "_quad"},  bus.rd_quad,  q);
        check_val({tag, "_wide"},  bus.rd_wide,  w);
        bus.rd_ready = 1'b1;
        step();
        bus.rd_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset_l = 1'b0;
        step();
        reset_l = 1'b1;
    endtask

    initial begin
        reset_l       = 1'b0;
        bus.cap_valid = 1'b0;
        bus.cap_small = '0;
        bus.cap_quad  = '0;
        bus.cap_wide  = '0;
        bus.rd_ready  = 1'b0;
        @(negedge clk);
        step();
        check_val("rst_rd_valid", bus.rd_valid, 1'b0);
        check_val("rst_empty",    empty,        1'b1);
        check_val("rst_full",     full,         1'b0);
        check_val("rst_count",    count,        3'd0);
        check_val("rst_ovf",      ovf,          1'b0);
        check_val("rst_rd_wide",  bus.rd_wide,  70'h0);
        reset_l = 1'b1;

        // 1: single capture, latency one, then pop
        push_one(2'b11, 40'h00_0000_0001, 70'h1);
        check_val("t1_count", count, 3'd1);
        pop_check("t1", 2'b11, 40'h1, 70'h1);
        check_val("t1_empty", empty, 1'b1);
        check_val("t1_rd_valid", bus.rd_valid, 1'b0);

        // 2: fill, drop the fifth, drain in order
        for (int i = 1; i <= 4; i++) push_one(2'(i), 40'(i), 70'(i));
        check_val("t2_full",  full,  1'b1);
        check_val("t2_count", count, 3'd4);
        push_one(2'd1, 40'd5, 70'd5);
        check_val("t2_ovf",     ovf,     1'b1);
        check_val("t2_ovf_cnt", ovf_cnt, 16'd1);
        check_val("t2_count_after_drop", count, 3'd4);
        for (int i = 1; i <= 4; i++) pop_check("t2_drain", 2'(i), 40'(i), 70'(i));
        check_val("t2_empty", empty, 1'b1);

        // 3: push+pop while full, no drop
        for (int i = 10; i <= 13; i++) push_one(2'(i), 40'(i), 70'(i));
        bus.rd_ready = 1'b1;
        push_one(2'(14), 40'd14, 70'd14);
        bus.rd_ready = 1'b0;
        check_val("t3_count",   count,   3'd4);
        check_val("t3_ovf_cnt", ovf_cnt, 16'd1);
        for (int i = 11; i <= 14; i++) pop_check("t3_drain", 2'(i), 40'(i), 70'(i));
        check_val("t3_empty", empty, 1'b1);

        // 4: pointer wrap with alternating patterns
        do_reset();
        check_val("t4_ovf_rst", ovf, 1'b0);
        for (int i = 0; i < 10; i++) begin
            logic [69:0] w;
            logic [39:0] q;
            logic [1:0]  s;
            w = (i % 2 == 0) ? ONES70 : 70'h0;
            q = (i % 2 == 0) ? 40'hFF_FFFF_FFFF : 40'h0;
            s = (i % 2 == 0) ? 2'b11 : 2'b00;
            push_one(s, q, w);
            pop_check("t4_wrap", s, q, w);
        end
        check_val("t4_ovf",   ovf,   1'b0);
        check_val("t4_empty", empty, 1'b1);

        // 5: reset with three entries queued and ovf set
        for (int i = 1; i <= 5; i++) push_one(2'(i), 40'(i), 70'(i));
        pop_check("t5_pre", 2'd1, 40'd1, 70'd1);
        check_val("t5_count_pre", count, 3'd3);
        check_val("t5_ovf_pre",   ovf,   1'b1);
        reset_l = 1'b0;
        step();
        check_val("t5_count",    count,        3'd0);
        check_val("t5_rd_valid", bus.rd_valid, 1'b0);
        check_val("t5_rd_small", bus.rd_small, 2'd0);
        check_val("t5_rd_quad",  bus.rd_quad,  40'd0);
        check_val("t5_rd_wide",  bus.rd_wide,  70'd0);
        check_val("t5_ovf",      ovf,          1'b0);
        check_val("t5_ovf_cnt",  ovf_cnt,      16'd0);
        check_val("t5_empty",    empty,        1'b1);
        reset_l = 1'b1;
        step();
        check_val("t5_empty_after", empty, 1'b1);

        // 6: checksum
        push_one(2'h1, 40'h3, 70'h5);
`ifdef MY_OUT_CAPTURE_CHKSUM_EN
        check_val("t6_chk_first", chk, 70'h7);
`else
        check_val("t6_chk_off", chk, 70'h0);
`endif
        push_one(2'h1, 40'h3, 70'h5);
        check_val("t6_chk_second", chk, 70'h0);
        push_one(2'h0, 40'h0, 70'h8);
        push_one(2'h0, 40'h0, 70'h10);
        check_val("t6_full", full, 1'b1);
        push_one(2'h3, 40'hFF, 70'hFF);
        check_val("t6_drop_cnt", ovf_cnt, 16'd1);
`ifdef MY_OUT_CAPTURE_CHKSUM_EN
        check_val("t6_chk_drop", chk, 70'h18);
`else
        check_val("t6_chk_drop_off", chk, 70'h0);
`endif
        pop_check("t6_head", 2'h1, 40'h3, 70'h5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
